ctrl_pipe: RTL and testbench
============================

Name: ctrl_pipe

Overview:
- Parametrised successor to the single-cycle opcode decoder: decodes the ID-stage opcode and carries the control bundle through ID/EX, EX/MEM and MEM/WB control registers.
- Inserts bubbles on flush and on load-use hazard, and freezes on stall.
- Sits between the IF/ID register and the datapath of the 5-stage MIPS pipeline. It is the sole source of per-stage control.

Parameters:
- OP_W, 6, opcode field width
- REG_W, 5, register-address width
- ALUOP_W, 2, ALU-op code width
- CNT_W, 16, performance-counter width (optional feature only)

Ports:
- Clk  in  1  clock, rising edge
- Start  in  1  asynchronous active-low reset; 0 clears all state
- valid_i  in  1  ID-stage instruction valid
- op_i  in  OP_W  ID-stage opcode
- rs_i  in  REG_W  ID-stage rs field
- rt_i  in  REG_W  ID-stage rt field
- stall_i  in  1  global freeze, e.g. memory wait
- flush_i  in  1  branch taken in MEM; kill younger instructions
- hazard_o  out  1  load-use hazard; upstream holds PC and IF/ID
- jump_o  out  1  ID-stage jump
- illegal_o  out  1  ID-stage opcode not in table
- ex_RegDst_o, ex_ALUSrc_o  out  1 each  EX controls
- ex_ALUOp_o  out  ALUOP_W  EX ALU op
- mem_MemRead_o, mem_MemWrite_o, mem_Branch_o  out  1 each  MEM controls
- wb_RegWrite_o, wb_MemtoReg_o  out  1 each  WB controls
- bubble_cnt_o, instr_cnt_o  out  CNT_W each  optional-feature counters

Behaviour:
- Decode table. Field order: RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump, ALUOp.
  - R-type 000000: 1,0,0,1,0,0,0,0,10
  - addi 001000: 0,1,0,1,0,0,0,0,00
  - lw 100011: 0,1,1,1,1,0,0,0,00
  - sw 101011: x,1,x,0,0,1,0,0,00 (x driven 0)
  - beq 000100: x,0,x,0,0,0,1,0,01 (x driven 0)
  - j 000010: all 0 except Jump=1
  - any other opcode: all-zero bundle; illegal_o = valid_i.
- Hazard detection is combinational:
  - hazard_o = valid_i & ex_MemRead & (ex_rt != 0) & ((ex_rt == rs_i) | (ex_rt == rt_i)).
  - ex_rt is rt_i captured into ID/EX alongside the bundle.
- jump_o = valid_i & dec.Jump & ~stall_i & ~flush_i.
- Pipeline latency: bundle decoded at ID in cycle n appears on ex_* in cycle n+1, mem_* in n+2, wb_* in n+3.
- Per rising Clk, highest priority first:
  - stall_i=1: all three stage registers hold; flush_i and hazard are ignored that cycle.
  - flush_i=1: ID/EX and EX/MEM load all-zero bubbles; MEM/WB loads from EX/MEM normally.
  - hazard_o=1 or valid_i=0: ID/EX loads a bubble; EX/MEM and MEM/WB advance.
  - Otherwise: all stages advance; ID/EX loads the decoded bundle.
- Bubble = all control bits 0 and ex_rt = 0; never causes a hazard.
- Reset: Start=0 asynchronously zeroes every stage register, ex_rt and the counters. All registered outputs read 0 while Start=0.
  - Combinational outputs (hazard_o, jump_o, illegal_o) follow inputs but evaluate against zeroed stages.
  - Start deasserting mid-stream: the first post-reset edge loads from the current ID inputs.
- Simultaneous flush_i and hazard_o: flush wins; hazard_o is still reported (harmless, since IF/ID is also flushed upstream).

Optional Feature:
- Macro: CTRL_PERF_CNT_EN.
- Defined:
  - instr_cnt_o increments on each non-stalled edge where ID/EX loads a non-bubble bundle.
  - bubble_cnt_o increments on each non-stalled edge where ID/EX loads a bubble because of hazard_o or flush_i. valid_i=0 does not count.
  - Both counters saturate at all-ones and clear on Start=0.
- Undefined: both ports tied to 0; no counter flops are synthesised.

Decomposition:
- Package ctrl_pkg holds:
  - opcode localparams OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J
  - ALUOp localparams ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10
  - packed struct ctrl_bundle_t with the nine fields of the decode table, plus the constant CTRL_BUBBLE.
- One sub-module, ctrl_decode: purely combinational op_i -> ctrl_bundle_t plus an illegal flag.
- Stage registers, hazard logic and counters live in ctrl_pipe.

Test Plan:
- Reset and idle: hold Start=0 for 2 cycles with op_i=100011 and valid_i=1 -> all ex_/mem_/wb_ outputs 0. Release -> ex_ALUSrc_o=1 next cycle; mem_MemRead_o=1 at +2; wb_MemtoReg_o=1 and wb_RegWrite_o=1 at +3.
- R-type stream: feed 000000 for 3 cycles -> ex_RegDst_o=1 and ex_ALUOp_o=10 from +1; wb_RegWrite_o=1 from +3.
- Load-use: lw with rt=8, then add with rs_i=8 -> hazard_o=1 for exactly one cycle; ex_* all 0 in the following cycle; add reaches EX one cycle later. Repeat with rt=0 -> hazard_o stays 0.
- Flush: beq reaches MEM while flush_i=1 for one cycle -> ID/EX and EX/MEM read bubbles next cycle; mem_Branch_o of beq passes to WB stage unchanged; jump_o is masked during the flush.
- Stall: assert stall_i for 3 cycles mid-stream, including one stall coincident with flush_i=1 -> all stage outputs frozen for 3 cycles, flush ignored; stream resumes intact afterwards.
- Illegal opcode and counters: op_i=111111 with valid_i=1 -> illegal_o=1 and an all-zero bundle. Under CTRL_PERF_CNT_EN, after the load-use and flush tests bubble_cnt_o=2. Preset both counters to all-ones and run a mix of valid instructions, hazards and flushes -> both counters stay at all-ones.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared control-bundle types, opcode/ALUOp encodings and per-stage control slices
// for the pipelined MIPS control unit.
package ctrl_pkg;

    localparam int CTRL_ALUOP_W = 2;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [CTRL_ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [CTRL_ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [CTRL_ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic                    RegDst;
        logic                    ALUSrc;
        logic                    MemtoReg;
        logic                    RegWrite;
        logic                    MemRead;
        logic                    MemWrite;
        logic                    Branch;
        logic                    Jump;
        logic [CTRL_ALUOP_W-1:0] ALUOp;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t CTRL_BUBBLE = '0;

    // Each pipeline register only keeps the controls still needed downstream of it.
    typedef struct packed {
        logic                    RegDst;
        logic                    ALUSrc;
        logic [CTRL_ALUOP_W-1:0] ALUOp;
    } ex_ctrl_t;

    typedef struct packed {
        logic MemRead;
        logic MemWrite;
        logic Branch;
    } mem_ctrl_t;

    typedef struct packed {
        logic RegWrite;
        logic MemtoReg;
    } wb_ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational ID-stage opcode decoder: opcode -> control bundle plus an
// illegal-opcode flag (unknown opcodes produce the all-zero bundle).
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  logic [OP_W-1:0] op_i,
    output ctrl_bundle_t    ctrl_o,
    output logic            illegal_o
);

    always_comb begin
        ctrl_o    = CTRL_BUBBLE;
        illegal_o = 1'b0;
        case (op_i)
            OP_W'(OP_RTYPE): begin
                ctrl_o.RegDst   = 1'b1;
                ctrl_o.RegWrite = 1'b1;
                ctrl_o.ALUOp    = ALUOP_FUNCT;
            end
            OP_W'(OP_ADDI): begin
                ctrl_o.ALUSrc   = 1'b1;
                ctrl_o.RegWrite = 1'b1;
                ctrl_o.ALUOp    = ALUOP_ADD;
            end
            OP_W'(OP_LW): begin
                ctrl_o.ALUSrc   = 1'b1;
                ctrl_o.MemtoReg = 1'b1;
                ctrl_o.RegWrite = 1'b1;
                ctrl_o.MemRead  = 1'b1;
                ctrl_o.ALUOp    = ALUOP_ADD;
            end
            OP_W'(OP_SW): begin
                ctrl_o.ALUSrc   = 1'b1;
                ctrl_o.MemWrite = 1'b1;
                ctrl_o.ALUOp    = ALUOP_ADD;
            end
            OP_W'(OP_BEQ): begin
                ctrl_o.Branch = 1'b1;
                ctrl_o.ALUOp  = ALUOP_SUB;
            end
            OP_W'(OP_J): begin
                ctrl_o.Jump = 1'b1;
            end
            default: begin
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ctrl_pipe.sv
// Pipelined control unit: decodes at ID and carries controls through ID/EX, EX/MEM and
// MEM/WB with stall/flush/load-use handling. Build with CTRL_PERF_CNT_EN for counters.
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int REG_W   = 5,
    parameter int ALUOP_W = 2,
    parameter int CNT_W   = 16
) (
    input  logic               Clk,
    input  logic               Start,
    input  logic               valid_i,
    input  logic [OP_W-1:0]    op_i,
    input  logic [REG_W-1:0]   rs_i,
    input  logic [REG_W-1:0]   rt_i,
    input  logic               stall_i,
    input  logic               flush_i,
    output logic               hazard_o,
    output logic               jump_o,
    output logic               illegal_o,
    output logic               ex_RegDst_o,
    output logic               ex_ALUSrc_o,
    output logic [ALUOP_W-1:0] ex_ALUOp_o,
    output logic               mem_MemRead_o,
    output logic               mem_MemWrite_o,
    output logic               mem_Branch_o,
    output logic               wb_RegWrite_o,
    output logic               wb_MemtoReg_o,
    output logic [CNT_W-1:0]   bubble_cnt_o,
    output logic [CNT_W-1:0]   instr_cnt_o
);

    ctrl_bundle_t dec;
    logic         decIllegal;
    logic         hazard;

    ex_ctrl_t     idexEx_q,  idexEx_d;
    mem_ctrl_t    idexMem_q, idexMem_d;
    wb_ctrl_t     idexWb_q,  idexWb_d;
    logic [REG_W-1:0] exRt_q, exRt_d;
    mem_ctrl_t    exmemMem_q, exmemMem_d;
    wb_ctrl_t     exmemWb_q,  exmemWb_d;
    wb_ctrl_t     memwbWb_q,  memwbWb_d;

    ctrl_decode #(.OP_W(OP_W)) u_decode (
        .op_i      (op_i),
        .ctrl_o    (dec),
        .illegal_o (decIllegal)
    );

    // A bubble clears exRt, so a zeroed ID/EX can never report a load-use hazard.
    assign hazard = valid_i & idexMem_q.MemRead & (exRt_q != '0)
                  & ((exRt_q == rs_i) | (exRt_q == rt_i));

    assign hazard_o  = hazard;
    assign jump_o    = valid_i & dec.Jump & ~stall_i & ~flush_i;
    assign illegal_o = valid_i & decIllegal;

    always_comb begin
        idexEx_d   = idexEx_q;
        idexMem_d  = idexMem_q;
        idexWb_d   = idexWb_q;
        exRt_d     = exRt_q;
        exmemMem_d = exmemMem_q;
        exmemWb_d  = exmemWb_q;
        memwbWb_d  = memwbWb_q;
        if (!stall_i) begin
            memwbWb_d = exmemWb_q;
            if (flush_i) begin
                idexEx_d   = '0;
                idexMem_d  = '0;
                idexWb_d   = '0;
                exRt_d     = '0;
                exmemMem_d = '0;
                exmemWb_d  = '0;
            end else begin
                exmemMem_d = idexMem_q;
                exmemWb_d  = idexWb_q;
                if (hazard || !valid_i) begin
                    idexEx_d  = '0;
                    idexMem_d = '0;
                    idexWb_d  = '0;
                    exRt_d    = '0;
                end else begin
                    idexEx_d.RegDst    = dec.RegDst;
                    idexEx_d.ALUSrc    = dec.ALUSrc;
                    idexEx_d.ALUOp     = dec.ALUOp;
                    idexMem_d.MemRead  = dec.MemRead;
                    idexMem_d.MemWrite = dec.MemWrite;
                    idexMem_d.Branch   = dec.Branch;
                    idexWb_d.RegWrite  = dec.RegWrite;
                    idexWb_d.MemtoReg  = dec.MemtoReg;
                    exRt_d             = rt_i;
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Start) begin
        if (!Start) begin
            idexEx_q   <= '0;
            idexMem_q  <= '0;
            idexWb_q   <= '0;
            exRt_q     <= '0;
            exmemMem_q <= '0;
            exmemWb_q  <= '0;
            memwbWb_q  <= '0;
        end else begin
            idexEx_q   <= idexEx_d;
            idexMem_q  <= idexMem_d;
            idexWb_q   <= idexWb_d;
            exRt_q     <= exRt_d;
            exmemMem_q <= exmemMem_d;
            exmemWb_q  <= exmemWb_d;
            memwbWb_q  <= memwbWb_d;
        end
    end

    assign ex_RegDst_o    = idexEx_q.RegDst;
    assign ex_ALUSrc_o    = idexEx_q.ALUSrc;
    assign ex_ALUOp_o     = ALUOP_W'(idexEx_q.ALUOp);
    assign mem_MemRead_o  = exmemMem_q.MemRead;
    assign mem_MemWrite_o = exmemMem_q.MemWrite;
    assign mem_Branch_o   = exmemMem_q.Branch;
    assign wb_RegWrite_o  = memwbWb_q.RegWrite;
    assign wb_MemtoReg_o  = memwbWb_q.MemtoReg;

`ifdef CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] bubbleCnt_q, bubbleCnt_d;
    logic [CNT_W-1:0] instrCnt_q,  instrCnt_d;

    // An illegal opcode loads an all-zero bundle, so it is not counted as an instruction.
    always_comb begin
        bubbleCnt_d = bubbleCnt_q;
        instrCnt_d  = instrCnt_q;
        if (!stall_i) begin
            if (flush_i || hazard) begin
                if (bubbleCnt_q != '1) bubbleCnt_d = bubbleCnt_q + CNT_W'(1);
            end else if (valid_i && !decIllegal) begin
                if (instrCnt_q != '1) instrCnt_d = instrCnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge Clk or negedge Start) begin
        if (!Start) begin
            bubbleCnt_q <= '0;
            instrCnt_q  <= '0;
        end else begin
            bubbleCnt_q <= bubbleCnt_d;
            instrCnt_q  <= instrCnt_d;
        end
    end

    assign bubble_cnt_o = bubbleCnt_q;
    assign instr_cnt_o  = instrCnt_q;
`else
    assign bubble_cnt_o = '0;
    assign instr_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed self-checking bench for ctrl_pipe: reset, streams, load-use, flush, stall,
// illegal opcode and (with CTRL_PERF_CNT_EN) counter values and saturation.
module tb_ctrl_pipe;

    localparam int TB_CNT_W = 4;
    localparam int K_BUB  = 0;
    localparam int K_R    = 1;
    localparam int K_ADDI = 2;
    localparam int K_LW   = 3;
    localparam int K_SW   = 4;
    localparam int K_BEQ  = 5;
    localparam int K_J    = 6;

    logic                Clk;
    logic                Start;
    logic                valid_i;
    logic [5:0]          op_i;
    logic [4:0]          rs_i;
    logic [4:0]          rt_i;
    logic                stall_i;
    logic                flush_i;
    logic                hazard_o;
    logic                jump_o;
    logic                illegal_o;
    logic                ex_RegDst_o;
    logic                ex_ALUSrc_o;
    logic [1:0]          ex_ALUOp_o;
    logic                mem_MemRead_o;
    logic                mem_MemWrite_o;
    logic                mem_Branch_o;
    logic                wb_RegWrite_o;
    logic                wb_MemtoReg_o;
    logic [TB_CNT_W-1:0] bubble_cnt_o;
    logic [TB_CNT_W-1:0] instr_cnt_o;

    int assertCount = 0;
    int failCount   = 0;

    ctrl_pipe #(.CNT_W(TB_CNT_W)) dut (
        .Clk            (Clk),
        .Start          (Start),
        .valid_i        (valid_i),
        .op_i           (op_i),
        .rs_i           (rs_i),
        .rt_i           (rt_i),
        .stall_i        (stall_i),
        .flush_i        (flush_i),
        .hazard_o       (hazard_o),
        .jump_o         (jump_o),
        .illegal_o      (illegal_o),
        .ex_RegDst_o    (ex_RegDst_o),
        .ex_ALUSrc_o    (ex_ALUSrc_o),
        .ex_ALUOp_o     (ex_ALUOp_o),
        .mem_MemRead_o  (mem_MemRead_o),
        .mem_MemWrite_o (mem_MemWrite_o),
        .mem_Branch_o   (mem_Branch_o),
        .wb_RegWrite_o  (wb_RegWrite_o),
        .wb_MemtoReg_o  (wb_MemtoReg_o),
        .bubble_cnt_o   (bubble_cnt_o),
        .instr_cnt_o    (instr_cnt_o)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Hand-written decode table, split per stage: {RegDst,ALUSrc,ALUOp}, {MemRead,MemWrite,Branch}, {RegWrite,MemtoReg}.
    function automatic logic [3:0] exOf(input int k);
        case (k)
            K_R:                 return 4'b1010;
            K_ADDI, K_LW, K_SW:  return 4'b0100;
            K_BEQ:               return 4'b0001;
            default:             return 4'b0000;
        endcase
    endfunction

    function automatic logic [2:0] memOf(input int k);
        case (k)
            K_LW:    return 3'b100;
            K_SW:    return 3'b010;
            K_BEQ:   return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [1:0] wbOf(input int k);
        case (k)
            K_R, K_ADDI: return 2'b10;
            K_LW:        return 2'b11;
            default:     return 2'b00;
        endcase
    endfunction

    function automatic logic [5:0] opOf(input int k);
        case (k)
            K_R:     return 6'b000000;
            K_ADDI:  return 6'b001000;
            K_LW:    return 6'b100011;
            K_SW:    return 6'b101011;
            K_BEQ:   return 6'b000100;
            K_J:     return 6'b000010;
            default: return 6'b111111;
        endcase
    endfunction

    function automatic logic [8:0] obsVec();
        return {ex_RegDst_o, ex_ALUSrc_o, ex_ALUOp_o, mem_MemRead_o, mem_MemWrite_o,
                mem_Branch_o, wb_RegWrite_o, wb_MemtoReg_o};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic checkStages(input string tag, input int kEx, input int kMem, input int kWb);
        checkOutput(tag, {23'b0, obsVec()}, {23'b0, exOf(kEx), memOf(kMem), wbOf(kWb)});
    endtask

    task automatic applyStimulus(input logic v, input int k, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic st, input logic fl);
        valid_i = v;
        op_i    = opOf(k);
        rs_i    = rs;
        rt_i    = rt;
        stall_i = st;
        flush_i = fl;
        #1;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, K_BUB, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    initial begin
        Start = 1'b0;
        applyStimulus(1'b1, K_LW, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        checkStages("reset_c1", K_BUB, K_BUB, K_BUB);
        checkOutput("reset_hazard", {31'b0, hazard_o}, 32'd0);
        tick();
        checkStages("reset_c2", K_BUB, K_BUB, K_BUB);
        checkOutput("reset_bubble_cnt", {28'b0, bubble_cnt_o}, 32'd0);
        checkOutput("reset_instr_cnt", {28'b0, instr_cnt_o}, 32'd0);

        Start = 1'b1;
        tick();
        checkStages("lw_ex", K_LW, K_BUB, K_BUB);
        checkOutput("lw_ex_ALUSrc", {31'b0, ex_ALUSrc_o}, 32'd1);
        idle();
        checkOutput("illegal_needs_valid", {31'b0, illegal_o}, 32'd0);
        tick();
        checkStages("lw_mem", K_BUB, K_LW, K_BUB);
        tick();
        checkStages("lw_wb", K_BUB, K_BUB, K_LW);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, K_R, 5'd1, 5'd2, 1'b0, 1'b0);
            checkOutput("rtype_no_illegal", {31'b0, illegal_o}, 32'd0);
            tick();
            checkStages("rtype_stream", K_R, (i >= 1) ? K_R : K_BUB, (i >= 2) ? K_R : K_BUB);
        end
        idle();
        tick(); checkStages("rtype_drain1", K_BUB, K_R, K_R);
        tick(); checkStages("rtype_drain2", K_BUB, K_BUB, K_R);
        tick(); checkStages("rtype_drain3", K_BUB, K_BUB, K_BUB);

        applyStimulus(1'b1, K_LW, 5'd0, 5'd8, 1'b0, 1'b0);
        checkOutput("lu_lw_no_hazard", {31'b0, hazard_o}, 32'd0);
        tick();
        applyStimulus(1'b1, K_R, 5'd8, 5'd9, 1'b0, 1'b0);
        checkOutput("lu_hazard", {31'b0, hazard_o}, 32'd1);
        tick();
        checkStages("lu_bubble", K_BUB, K_LW, K_BUB);
        checkOutput("lu_hazard_one_cycle", {31'b0, hazard_o}, 32'd0);
        tick();
        checkStages("lu_add_in_ex", K_R, K_BUB, K_LW);

        applyStimulus(1'b1, K_LW, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        checkStages("lu0_lw", K_LW, K_R, K_BUB);
        applyStimulus(1'b1, K_R, 5'd0, 5'd0, 1'b0, 1'b0);
        checkOutput("lu0_no_hazard", {31'b0, hazard_o}, 32'd0);
        tick();
        checkStages("lu0_add", K_R, K_LW, K_R);
        idle();
        tick(); checkStages("lu0_drain1", K_BUB, K_R, K_LW);
        tick(); checkStages("lu0_drain2", K_BUB, K_BUB, K_R);
        tick(); checkStages("lu0_drain3", K_BUB, K_BUB, K_BUB);

        applyStimulus(1'b1, K_BEQ, 5'd1, 5'd2, 1'b0, 1'b0);
        tick();
        checkStages("fl_beq_ex", K_BEQ, K_BUB, K_BUB);
        applyStimulus(1'b1, K_ADDI, 5'd3, 5'd4, 1'b0, 1'b0);
        tick();
        checkStages("fl_beq_mem", K_ADDI, K_BEQ, K_BUB);
        checkOutput("fl_mem_branch", {31'b0, mem_Branch_o}, 32'd1);
        applyStimulus(1'b1, K_J, 5'd0, 5'd0, 1'b0, 1'b1);
        checkOutput("fl_jump_masked", {31'b0, jump_o}, 32'd0);
        tick();
        checkStages("fl_bubbles", K_BUB, K_BUB, K_BEQ);
        applyStimulus(1'b1, K_J, 5'd0, 5'd0, 1'b0, 1'b0);
        checkOutput("jump_unmasked", {31'b0, jump_o}, 32'd1);
        tick();
        checkStages("jump_ex", K_J, K_BUB, K_BUB);
        idle();
        tick(); tick(); tick();
        checkStages("fl_drain", K_BUB, K_BUB, K_BUB);
`ifdef CTRL_PERF_CNT_EN
        checkOutput("cnt_bubble_2", {28'b0, bubble_cnt_o}, 32'd2);
        checkOutput("cnt_instr_11", {28'b0, instr_cnt_o}, 32'd11);
`else
        checkOutput("cnt_bubble_tied", {28'b0, bubble_cnt_o}, 32'd0);
        checkOutput("cnt_instr_tied", {28'b0, instr_cnt_o}, 32'd0);
`endif

        applyStimulus(1'b1, K_R, 5'd1, 5'd2, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, K_LW, 5'd3, 5'd5, 1'b0, 1'b0);
        tick();
        checkStages("st_pre", K_LW, K_R, K_BUB);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, K_ADDI, 5'd6, 5'd7, 1'b1, (i == 1));
            tick();
            checkStages("st_frozen", K_LW, K_R, K_BUB);
        end
        applyStimulus(1'b1, K_ADDI, 5'd6, 5'd7, 1'b0, 1'b0);
        checkOutput("st_no_hazard", {31'b0, hazard_o}, 32'd0);
        tick();
        checkStages("st_resume1", K_ADDI, K_LW, K_R);
        applyStimulus(1'b1, K_SW, 5'd9, 5'd10, 1'b0, 1'b0);
        tick();
        checkStages("st_resume2", K_SW, K_ADDI, K_LW);
        idle();
        tick(); checkStages("st_drain1", K_BUB, K_SW, K_ADDI);
        tick(); checkStages("st_drain2", K_BUB, K_BUB, K_SW);
        tick(); checkStages("st_drain3", K_BUB, K_BUB, K_BUB);

        applyStimulus(1'b1, K_BUB, 5'd1, 5'd2, 1'b0, 1'b0);
        checkOutput("illegal_flag", {31'b0, illegal_o}, 32'd1);
        checkOutput("illegal_no_jump", {31'b0, jump_o}, 32'd0);
        tick();
        checkStages("illegal_zero_bundle", K_BUB, K_BUB, K_BUB);

`ifdef CTRL_PERF_CNT_EN
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, K_LW, 5'd0, 5'd8, 1'b0, 1'b0);
            tick();
            applyStimulus(1'b1, K_R, 5'd8, 5'd1, 1'b0, 1'b0);
            tick();
            tick();
            applyStimulus(1'b0, K_BUB, 5'd0, 5'd0, 1'b0, 1'b1);
            tick();
        end
        idle();
        checkOutput("cnt_bubble_sat", {28'b0, bubble_cnt_o}, 32'd15);
        checkOutput("cnt_instr_sat", {28'b0, instr_cnt_o}, 32'd15);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
